enc_round_sequencer: RTL and testbench

Multi-round controller for the team's 8-bit nibble-Feistel encryption round. It accepts a plaintext/key pair over a valid/ready handshake and iterates the single-round function ROUNDS times, one round per clock. Between rounds it swaps nibbles and rotates the round key. The ciphertext is presented on a valid/ready output port. It sits between the host-side number/key source and any downstream consumer of encrypted bytes.

---
 rtl/enc_round_sequencer.sv | 101 ++++++++++
 tb/tb_enc_round_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/enc_round_sequencer.sv
// Multi-round controller for the 8-bit nibble-Feistel round: loads a plaintext/key
// pair, applies ROUNDS rounds one per clock, then offers the ciphertext on a valid/ready port.
module enc_round_sequencer #(
    parameter int unsigned ROUNDS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_number,
    input  logic [7:0] in_key,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    output logic [3:0] round_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    fsm_t       fsm, fsm_next;
    logic [7:0] state, state_next;
    logic [7:0] key_reg, key_next;
    logic [3:0] cnt_next;
    logic [7:0] f_out;

    // Single round: expand the low nibble, mix with the key, fold to a nibble and
    // xor it into the high nibble; the low nibble passes through unchanged.
    function automatic logic [7:0] round_f(input logic [7:0] n, input logic [7:0] k);
        logic [7:0] e;
        logic [7:0] x;
        logic [3:0] s;
        e = {n[3], n[0], n[1], n[2], n[1], n[3], n[2], n[0]};
        x = e ^ k;
        s = x[7:4] + x[3:0] + {3'b000, k[0]};
        return {n[7:4] ^ s, n[3:0]};
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm       <= IDLE;
            state     <= '0;
            key_reg   <= '0;
            round_cnt <= '0;
        end else begin
            fsm       <= fsm_next;
            state     <= state_next;
            key_reg   <= key_next;
            round_cnt <= cnt_next;
        end
    end

    always_comb begin
        fsm_next   = fsm;
        state_next = state;
        key_next   = key_reg;
        cnt_next   = round_cnt;
        f_out      = round_f(state, key_reg);
        case (fsm)
            IDLE: begin
                if (in_valid) begin
                    state_next = in_number;
                    key_next   = in_key;
                    cnt_next   = '0;
                    fsm_next   = RUN;
                end
            end
            RUN: begin
                key_next = {key_reg[6:0], key_reg[7]};
                cnt_next = round_cnt + 4'd1;
                // The final round skips the nibble swap.
                if (round_cnt == LAST_ROUND) begin
                    state_next = f_out;
                    fsm_next   = DONE;
                end else begin
                    state_next = {f_out[3:0], f_out[7:4]};
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm == RUN) || (fsm == DONE);
    assign out_data  = state;

endmodule

// File: tb/tb_enc_round_sequencer.sv
// Bench for enc_round_sequencer: three instances (ROUNDS=1,2,4) checked against an
// arithmetic model of the cipher with directed and randomized jobs.
module tb_enc_round_sequencer;

    logic       clock = 1'b0;
    logic       rst   [3];
    logic       iv    [3];
    logic       ordy  [3];
    logic [7:0] num   [3];
    logic [7:0] key   [3];
    logic       ir    [3];
    logic       ov    [3];
    logic       bz    [3];
    logic [7:0] od    [3];
    logic [3:0] rc    [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    enc_round_sequencer #(.ROUNDS(1)) dut_r1 (
        .clock(clock), .reset(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_number(num[0]), .in_key(key[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_data(od[0]), .busy(bz[0]), .round_cnt(rc[0])
    );
    enc_round_sequencer #(.ROUNDS(2)) dut_r2 (
        .clock(clock), .reset(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_number(num[1]), .in_key(key[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_data(od[1]), .busy(bz[1]), .round_cnt(rc[1])
    );
    enc_round_sequencer #(.ROUNDS(4)) dut_r4 (
        .clock(clock), .reset(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_number(num[2]), .in_key(key[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_data(od[2]), .busy(bz[2]), .round_cnt(rc[2])
    );

    function automatic int rounds_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    // Round function from its defining rules, using integer arithmetic.
    function automatic int f_ref(input int n, input int k);
        int src[8];
        int e;
        int x;
        int s;
        src = '{0, 2, 3, 1, 2, 1, 0, 3};
        e = 0;
        for (int b = 0; b < 8; b++) e += ((n >> src[b]) & 1) << b;
        x = e ^ k;
        s = ((x >> 4) + (x & 15) + (k & 1)) % 16;
        return ((((n >> 4) ^ s) & 15) << 4) | (n & 15);
    endfunction

    // State after the first c rounds of an R-round job.
    function automatic logic [7:0] model_run(input int n, input int k, input int r_total, input int c);
        int st;
        int kk;
        int f;
        st = n;
        kk = k;
        for (int r = 0; r < c; r++) begin
            f  = f_ref(st, kk);
            st = (r < r_total - 1) ? (((f & 15) << 4) | (f >> 4)) : f;
            kk = ((kk << 1) | (kk >> 7)) & 255;
        end
        return 8'(st);
    endfunction

    task automatic run_job(input int i, input logic [7:0] n, input logic [7:0] k,
                           input int hold, input bit pulse, input int want);
        int r_total;
        logic [7:0] expv;
        r_total = rounds_of(i);
        expv = (want >= 0) ? 8'(want) : model_run(n, k, r_total, r_total);
        @(negedge clock);
        ordy[i] = (hold == 0);
        num[i] = n; key[i] = k; iv[i] = 1'b1;
        checks++; if (ir[i] !== 1'b1) begin failures++; $display("FAIL accept_ready inst=%0d got=%b exp=1", i, ir[i]); end
        @(negedge clock);
        iv[i] = 1'b0; num[i] = 8'($urandom); key[i] = 8'($urandom);
        checks++; if ({bz[i], ir[i], ov[i], rc[i]} !== {3'b100, 4'd0})
            begin failures++; $display("FAIL run_start inst=%0d got busy=%b rdy=%b vld=%b cnt=%0d exp 1 0 0 0", i, bz[i], ir[i], ov[i], rc[i]); end
        for (int c = 1; c <= r_total; c++) begin
            @(negedge clock);
            checks++; if (rc[i] !== 4'(c)) begin failures++; $display("FAIL round_cnt inst=%0d got=%0d exp=%0d", i, rc[i], c); end
            checks++; if (ov[i] !== (c == r_total)) begin failures++; $display("FAIL out_valid_timing inst=%0d round=%0d got=%b exp=%b", i, c, ov[i], c == r_total); end
            checks++; if (od[i] !== model_run(n, k, r_total, c))
                begin failures++; $display("FAIL round_state inst=%0d round=%0d got=%h exp=%h", i, c, od[i], model_run(n, k, r_total, c)); end
            checks++; if (ir[i] !== 1'b0) begin failures++; $display("FAIL ready_in_run inst=%0d got=%b exp=0", i, ir[i]); end
        end
        checks++; if (od[i] !== expv) begin failures++; $display("FAIL ciphertext inst=%0d got=%h exp=%h", i, od[i], expv); end
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 0) begin iv[i] = 1'b1; num[i] = ~n; key[i] = ~k; end
            @(negedge clock);
            iv[i] = 1'b0;
            checks++; if ({ov[i], ir[i], bz[i], rc[i], od[i]} !== {3'b101, 4'(r_total), expv})
                begin failures++; $display("FAIL backpressure_hold inst=%0d got vld=%b rdy=%b busy=%b cnt=%0d data=%h exp 1 0 1 %0d %h", i, ov[i], ir[i], bz[i], rc[i], od[i], r_total, expv); end
        end
        ordy[i] = 1'b1;
        @(negedge clock);
        ordy[i] = 1'b0;
        checks++; if ({ov[i], ir[i], bz[i], rc[i], od[i]} !== {3'b010, 4'(r_total), expv})
            begin failures++; $display("FAIL release inst=%0d got vld=%b rdy=%b busy=%b cnt=%0d data=%h exp 0 1 0 %0d %h", i, ov[i], ir[i], bz[i], rc[i], od[i], r_total, expv); end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; iv[i] = 1'b0; ordy[i] = 1'b0; num[i] = '0; key[i] = '0;
        end
        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({ir[i], ov[i], bz[i], od[i], rc[i]} !== {3'b100, 8'h00, 4'd0})
                begin failures++; $display("FAIL reset_state inst=%0d got rdy=%b vld=%b busy=%b data=%h cnt=%0d exp 1 0 0 00 0", i, ir[i], ov[i], bz[i], od[i], rc[i]); end
        end
    endtask

    task automatic test_single_round;
        run_job(0, 8'h46, 8'h93, 0, 1'b0, 8'h06);
    endtask

    task automatic test_two_rounds;
        run_job(1, 8'h46, 8'h93, 0, 1'b0, 8'hC0);
    endtask

    task automatic test_backpressure;
        run_job(0, 8'h00, 8'h01, 5, 1'b1, 8'h20);
        run_job(0, 8'h5A, 8'hC3, 0, 1'b0, -1);
    endtask

    task automatic test_abort;
        @(negedge clock);
        num[2] = 8'hA7; key[2] = 8'h3C; iv[2] = 1'b1; ordy[2] = 1'b0;
        @(negedge clock);
        iv[2] = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (rc[2] !== 4'd2) begin failures++; $display("FAIL abort_mid_run inst=2 got cnt=%0d exp=2", rc[2]); end
        rst[2] = 1'b1;
        @(negedge clock);
        rst[2] = 1'b0;
        checks++; if ({ir[2], ov[2], bz[2], od[2], rc[2]} !== {3'b100, 8'h00, 4'd0})
            begin failures++; $display("FAIL abort_idle got rdy=%b vld=%b busy=%b data=%h cnt=%0d exp 1 0 0 00 0", ir[2], ov[2], bz[2], od[2], rc[2]); end
        for (int t = 0; t < 6; t++) begin
            @(negedge clock);
            checks++; if (ov[2] !== 1'b0) begin failures++; $display("FAIL abort_no_valid cycle=%0d got=%b exp=0", t, ov[2]); end
        end
        run_job(2, 8'hA7, 8'h3C, 1, 1'b0, -1);
    endtask

    task automatic test_back_to_back;
        int acc[$];
        logic [7:0] expq[$];
        logic [7:0] e;
        int got;
        bit pend;
        got = 0;
        pend = 1'b0;
        @(negedge clock);
        num[1] = 8'($urandom); key[1] = 8'($urandom); iv[1] = 1'b1; ordy[1] = 1'b1;
        for (int t = 0; t < 40 && got < 2; t++) begin
            if (pend) begin num[1] = 8'($urandom); key[1] = 8'($urandom); pend = 1'b0; end
            checks++; if (ov[1] && ir[1]) begin failures++; $display("FAIL valid_ready_overlap got vld=%b rdy=%b exp not both", ov[1], ir[1]); end
            if (ov[1]) begin
                e = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
                checks++; if (od[1] !== e) begin failures++; $display("FAIL b2b_data job=%0d got=%h exp=%h", got, od[1], e); end
                got++;
            end
            if (ir[1]) begin
                acc.push_back(cyc);
                expq.push_back(model_run(num[1], key[1], 2, 2));
                pend = 1'b1;
            end
            @(negedge clock);
        end
        iv[1] = 1'b0;
        checks++; if (got !== 2) begin failures++; $display("FAIL b2b_timeout got=%0d outputs exp=2", got); end
        checks++; if (acc.size() < 2 || acc[1] - acc[0] != 4)
            begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", (acc.size() < 2) ? -1 : acc[1] - acc[0]); end
        @(negedge clock);
        ordy[1] = 1'b0;
        checks++; if (ir[1] !== 1'b1) begin failures++; $display("FAIL b2b_ready_return got=%b exp=1", ir[1]); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 5; j++) begin
                run_job(i, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), -1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_round();
        test_two_rounds();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
